// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
// Optional build macro: SEQ_DET_MASK_EN (adds a per-bit don't-care mask).
package seq_det_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 32;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 32;
    localparam int PAT_W_DEF = 5;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } det_state_e;

    // Wide enough to hold PAT_W-1 with headroom for the saturating compare.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
import seq_det_pkg::*;

module sat_counter #(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: shift history plus live bit against a pattern.
// Build macro SEQ_DET_MASK_EN adds pattern_mask (0 bit = don't care).
import seq_det_pkg::*;

module seq_detector_param #(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic [PAT_W-1:0] pattern,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] pattern_mask,
`endif
    input  logic             overlap_en,
    input  logic             clear,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_count
);

    localparam int FW = fill_w(PAT_W);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             match_reg_q;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] diff;
    logic             accept;
    det_state_e       state;

    assign window = {hist_q, in_bit};
    assign accept = in_valid & ~clear;
    assign state  = (fill_q == FILL_MAX) ? ST_ARMED : ST_FILL;

`ifdef SEQ_DET_MASK_EN
    assign diff = (window ^ pattern) & pattern_mask;
`else
    assign diff = window ^ pattern;
`endif

    assign match = accept & (state == ST_ARMED) & (diff == '0);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = window[PAT_W-2:0];
            // Non-overlap: stale history is ignored until fully refilled.
            if (match && !overlap_en) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q      <= '0;
            fill_q      <= '0;
            match_reg_q <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_reg_q <= match;
        end
    end

    assign match_q = match_reg_q;

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (match),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param (CNT_W=8 and CNT_W=2 instances).
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       clear = 1'b0;
    logic       overlap_en = 1'b1;
    logic [4:0] pattern = 5'b10101;
    logic [4:0] pattern_mask = 5'b11111;

    logic       match, match_q, match_s, match_q_s;
    logic [7:0] cnt;
    logic [1:0] cnt_s;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(5), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .pattern     (pattern),
`ifdef SEQ_DET_MASK_EN
        .pattern_mask(pattern_mask),
`endif
        .overlap_en  (overlap_en),
        .clear       (clear),
        .match       (match),
        .match_q     (match_q),
        .match_count (cnt)
    );

    seq_detector_param #(.PAT_W(5), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .pattern     (pattern),
`ifdef SEQ_DET_MASK_EN
        .pattern_mask(pattern_mask),
`endif
        .overlap_en  (overlap_en),
        .clear       (clear),
        .match       (match_s),
        .match_q     (match_q_s),
        .match_count (cnt_s)
    );

    typedef struct packed {
        logic       m;
        logic [7:0] c;
        logic [1:0] c2;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_a, mon_b;

    logic [3:0] m_hist;
    int         m_fill;
    logic [7:0] m_cnt;
    logic [1:0] m_cnt2;

    int n_checks = 0;
    int n_fail = 0;

    task automatic model_reset();
        m_hist = '0;
        m_fill = 0;
        m_cnt  = '0;
        m_cnt2 = '0;
    endtask

    // Drive one cycle of stimulus and queue what the reference model expects.
    task automatic drive(input logic v, input logic b, input logic c);
        exp_t       e;
        logic [4:0] win;
        logic       hit;
        in_valid = v;
        in_bit   = b;
        clear    = c;
        win = {m_hist, b};
        hit = v && !c && (m_fill == 4) && (((win ^ pattern) & pattern_mask) == 5'b0);
        if (c) begin
            model_reset();
        end else if (v) begin
            m_hist = win[3:0];
            if (hit && !overlap_en) m_fill = 0;
            else if (m_fill < 4) m_fill++;
            if (hit) begin
                if (m_cnt != 8'hFF) m_cnt++;
                if (m_cnt2 != 2'd3) m_cnt2++;
            end
        end
        e.m  = hit;
        e.c  = m_cnt;
        e.c2 = m_cnt2;
        q_a.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            mon_a = q_a.pop_front();
            n_checks++;
            if (match !== mon_a.m || match_s !== mon_a.m) begin
                n_fail++;
                $display("FAIL match: got %b/%b expected %b at %0t",
                         match, match_s, mon_a.m, $time);
            end
            q_b.push_back(mon_a);
        end
    end

    always @(posedge clk) begin
        #1;
        if (q_b.size() > 0) begin
            mon_b = q_b.pop_front();
            n_checks++;
            if (match_q !== mon_b.m || match_q_s !== mon_b.m) begin
                n_fail++;
                $display("FAIL match_q: got %b/%b expected %b at %0t",
                         match_q, match_q_s, mon_b.m, $time);
            end
            n_checks++;
            if (cnt !== mon_b.c || cnt_s !== mon_b.c2) begin
                n_fail++;
                $display("FAIL count: got %0d/%0d expected %0d/%0d at %0t",
                         cnt, cnt_s, mon_b.c, mon_b.c2, $time);
            end
        end
    end

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        clear    = 1'b0;
        #1;
        n_checks++;
        if (match !== 1'b0 || match_q !== 1'b0 || cnt !== 8'd0 || cnt_s !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: match=%b match_q=%b cnt=%0d cnt_s=%0d expected all 0",
                     match, match_q, cnt, cnt_s);
        end
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        pattern    = 5'b10101;
        overlap_en = 1'b1;
        s = 7'b1010101;
        for (int i = 6; i >= 0; i--) drive(1'b1, s[i], 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if (cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL overlap_count: got %0d expected 2", cnt);
        end
    endtask

    task automatic test_non_overlap();
        logic [6:0] s;
        drive(1'b0, 1'b0, 1'b1);
        pattern    = 5'b10101;
        overlap_en = 1'b0;
        s = 7'b1010101;
        for (int i = 6; i >= 0; i--) drive(1'b1, s[i], 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if (cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL non_overlap_count: got %0d expected 1", cnt);
        end
        overlap_en = 1'b1;
    endtask

    task automatic test_fill_guard();
        drive(1'b0, 1'b0, 1'b1);
        pattern = 5'b00000;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL fill_guard_early: got %0d expected 0", cnt);
        end
        drive(1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if (cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL fill_guard_fifth: got %0d expected 1", cnt);
        end
    endtask

    task automatic test_valid_gap();
        logic [3:0] s;
        drive(1'b0, 1'b0, 1'b1);
        pattern = 5'b10101;
        s = 4'b1010;
        for (int i = 3; i >= 0; i--) drive(1'b1, s[i], 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL gap_hold: got %0d expected 0", cnt);
        end
        drive(1'b1, 1'b1, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if (cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL gap_match: got %0d expected 1", cnt);
        end
    endtask

    task automatic test_saturation();
        drive(1'b0, 1'b0, 1'b1);
        pattern    = 5'b11111;
        overlap_en = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if (cnt_s !== 2'd3 || cnt !== 8'd6) begin
            n_fail++;
            $display("FAIL saturation: got %0d/%0d expected 3/6", cnt_s, cnt);
        end
    endtask

    task automatic test_clear();
        logic [7:0] s;
        drive(1'b0, 1'b0, 1'b1);
        pattern    = 5'b10101;
        overlap_en = 1'b1;
        s = 8'b10101010;
        for (int i = 7; i >= 0; i--) drive(1'b1, s[i], 1'b0);
        n_checks++;
        if (cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL clear_prime: got %0d expected 2", cnt);
        end
        drive(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (cnt !== 8'd0 || match_q !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_apply: cnt=%0d match_q=%b expected 0/0", cnt, match_q);
        end
        for (int i = 7; i >= 4; i--) drive(1'b1, s[i], 1'b0);
        n_checks++;
        if (cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_refill: got %0d expected 0", cnt);
        end
        drive(1'b1, 1'b1, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if (cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL clear_rearm: got %0d expected 1", cnt);
        end
    endtask

`ifdef SEQ_DET_MASK_EN
    task automatic test_mask();
        drive(1'b0, 1'b0, 1'b1);
        pattern      = 5'b10001;
        pattern_mask = 5'b10001;
        overlap_en   = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if (cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL mask: got %0d expected 1", cnt);
        end
        pattern_mask = 5'b11111;
        overlap_en   = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_overlap();
        test_reset();
        test_non_overlap();
        test_fill_guard();
        test_valid_gap();
        test_saturation();
        test_clear();
`ifdef SEQ_DET_MASK_EN
        test_mask();
`endif
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d left expected 0/0",
                     q_a.size(), q_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
